mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported `ram` between the `rv32i` instruction fetch port (read-only) and data port (read/write).
- Converts the split I/D bus into one memory bus, so the CPU can run from a unified memory image.
- Sits between `rv32i` and `ram`, using the same strobe/busy protocol on both sides.
- Buffers one request per port, arbitrates between them and returns read data in per-port holding registers.

Parameters:
- AW, 32, address width.
- DW, 32, data width; wmask width is DW/8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- i_addr  input  AW  fetch address, sampled with i_rstrb.
- i_rstrb  input  1  fetch read strobe, one-cycle pulse.
- i_rdata  output  DW  fetch data, held until the next fetch completes.
- i_rbusy  output  1  fetch pending or in flight.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_wmask  input  DW/8  byte-enable mask.
- d_wstrb  input  1  write strobe, one-cycle pulse.
- d_rstrb  input  1  read strobe, one-cycle pulse.
- d_rdata  output  DW  load data, held until the next D read completes.
- d_rbusy  output  1  D read pending or in flight.
- d_wbusy  output  1  D write pending or in flight.
- mem_addr  output  AW  to ram.
- mem_wdata  output  DW  to ram.
- mem_wmask  output  DW/8  to ram.
- mem_rstrb  output  1  to ram.
- mem_wstrb  output  1  to ram.
- mem_rdata  input  DW  from ram.
- mem_rbusy  input  1  from ram.
- mem_wbusy  input  1  from ram.

Behaviour:
- Reset (rst low, asynchronous):
  - All busy outputs, mem strobes, pending flags and holding registers go to 0.
  - FSM goes to IDLE; round-robin pointer set so the I port wins the first tie.
  - A reset mid-transaction drops the transaction; no completion is reported.
- Capture slot per port:
  - A strobe sampled at edge E latches addr, wdata, wmask and op into the slot and sets pending.
  - The port busy output goes high from cycle E+1.
  - A strobe while the port's busy is high is ignored.
  - d_wstrb and d_rstrb high together is treated as a write; d_rstrb is ignored.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any slot is pending, grant one and go to ISSUE.
  - ISSUE (exactly one cycle):
    - Drive mem_addr, mem_wdata and mem_wmask from the granted slot.
    - Drive mem_rstrb or mem_wstrb high.
    - Go to WAIT.
  - WAIT: each edge, sample the busy line matching the op (mem_rbusy for reads, mem_wbusy for writes).
    - Busy high: stay in WAIT.
    - Busy low, read: capture mem_rdata into that port's rdata register.
    - Busy low, any op: clear pending and the port busy.
    - Then go to ISSUE if the other slot is pending, else IDLE. There is no idle bubble between back-to-back grants.
- Outputs outside ISSUE:
  - mem strobes are 0.
  - mem_addr, mem_wdata and mem_wmask hold the last granted values.
- Latency, uncontended, zero-wait memory:
  - Strobe in cycle 0, mem strobe in cycle 1, port busy high in cycles 1-2.
  - Port busy low and rdata valid in cycle 3.
- Arbitration:
  - Round-robin when both slots are pending at grant time; the pointer toggles to the non-granted port after each grant.
  - A single pending slot is always granted.
  - A strobe arriving on the same edge a completion is sampled is captured; it becomes eligible for grant the following cycle.
- rdata registers change only on completion of that port's read; writes never modify d_rdata.
- Busy outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MEM_ARB_D_PRIORITY_EN.
  - Defined: fixed priority, the D port always wins a tie, and the round-robin pointer is removed.
  - Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2).
  - Port ID constants (PORT_I=1'b0, PORT_D=1'b1).
  - Op encoding (OP_RD=1'b0, OP_WR=1'b1).
- Sub-module mem_req_slot: the capture slot (addr/wdata/wmask/op registers, pending flag, rdata holding register).
  - Instantiated twice; the I instance ties its write inputs to 0.

Test Plan:
- I-only fetch: i_rstrb at cycle 0, addr 0x100, memory word 0xDEADBEEF, zero-wait → mem_rstrb=1 and mem_addr=0x100 in cycle 1; i_rbusy=1 in cycles 1-2; i_rdata=0xDEADBEEF and i_rbusy=0 in cycle 3.
- D write then read: d_wstrb to addr 0x20 with data 0x12345678 and wmask 4'b0011, then d_rstrb to 0x20, memory initially 0xAAAAAAAA → d_wbusy pulses; read returns d_rdata=0xAAAA5678.
- Simultaneous i_rstrb (0x0) and d_rstrb (0x40) after reset → I is granted first (mem_rstrb cycle 1, addr 0x0) and D is issued with no bubble after I completes. Repeat → D first. With MEM_ARB_D_PRIORITY_EN → D first on both repeats.
- Memory holds mem_rbusy high for 3 cycles after issue → port busy extends by 3 cycles. A second strobe on the same port while busy is ignored (exactly one mem_rstrb observed).
- rst driven low in WAIT with both slots pending → all busy and strobe outputs 0 immediately (asynchronous); after release, no mem strobe occurs without new requests.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states, port IDs and op codes.
package mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/mem_req_slot.sv
// One-deep request capture slot with pending flag and a read-data holding register.
module mem_req_slot
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            strb,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wmask,
   input  logic            op,
   input  logic            done,
   input  logic [DW-1:0]   mem_rdata,
   output logic            pending,
   output logic            op_cur,
   output logic            req_now,
   output logic [AW-1:0]   addr_next,
   output logic [DW-1:0]   wdata_next,
   output logic [DW/8-1:0] wmask_next,
   output logic            op_next,
   output logic [DW-1:0]   rdata
);
   logic            capture;
   logic            pending_reg;
   logic            op_reg;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wdata_reg;
   logic [DW/8-1:0] wmask_reg;
   logic [DW-1:0]   rdata_reg;

   // A strobe landing on the completion edge refills the slot immediately.
   assign capture    = strb && (!pending_reg || done);
   assign req_now    = pending_reg || capture;
   assign addr_next  = capture ? addr  : addr_reg;
   assign wdata_next = capture ? wdata : wdata_reg;
   assign wmask_next = capture ? wmask : wmask_reg;
   assign op_next    = capture ? op    : op_reg;

   assign pending = pending_reg;
   assign op_cur  = op_reg;
   assign rdata   = rdata_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_reg <= 1'b0;
         op_reg      <= OP_RD;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wmask_reg   <= '0;
         rdata_reg   <= '0;
      end else begin
         if (capture) begin
            pending_reg <= 1'b1;
            op_reg      <= op;
            addr_reg    <= addr;
            wdata_reg   <= wdata;
            wmask_reg   <= wmask;
         end else if (done) begin
            pending_reg <= 1'b0;
         end
         if (done && op_reg == OP_RD) begin
            rdata_reg <= mem_rdata;
         end
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between the rv32i fetch and data ports.
// MEM_ARB_D_PRIORITY_EN: D port wins ties (fixed priority) instead of round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   i_addr,
   input  logic            i_rstrb,
   output logic [DW-1:0]   i_rdata,
   output logic            i_rbusy,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wmask,
   input  logic            d_wstrb,
   input  logic            d_rstrb,
   output logic [DW-1:0]   d_rdata,
   output logic            d_rbusy,
   output logic            d_wbusy,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wmask,
   output logic            mem_rstrb,
   output logic            mem_wstrb,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_rbusy,
   input  logic            mem_wbusy
);
   logic [1:0]      port_strb, port_op;
   logic [AW-1:0]   port_addr [2];
   logic [DW-1:0]   port_wdata [2];
   logic [DW/8-1:0] port_wmask [2];

   logic [1:0]      slot_pending, slot_op, slot_req, slot_op_next, slot_done;
   logic [AW-1:0]   slot_addr_next [2];
   logic [DW-1:0]   slot_wdata_next [2];
   logic [DW/8-1:0] slot_wmask_next [2];
   logic [DW-1:0]   slot_rdata [2];

   arb_state_t      state_reg, state_next;
   logic            grant_reg, grant_next;
   logic            load_issue, sel_busy, done;
   logic [AW-1:0]   mem_addr_reg;
   logic [DW-1:0]   mem_wdata_reg;
   logic [DW/8-1:0] mem_wmask_reg;
   logic            mem_rstrb_reg, mem_wstrb_reg;

   assign port_strb[PORT_I]  = i_rstrb;
   assign port_op[PORT_I]    = OP_RD;
   assign port_addr[PORT_I]  = i_addr;
   assign port_wdata[PORT_I] = '0;
   assign port_wmask[PORT_I] = '0;

   // Simultaneous write and read strobes resolve to a write.
   assign port_strb[PORT_D]  = d_wstrb || d_rstrb;
   assign port_op[PORT_D]    = d_wstrb ? OP_WR : OP_RD;
   assign port_addr[PORT_D]  = d_addr;
   assign port_wdata[PORT_D] = d_wdata;
   assign port_wmask[PORT_D] = d_wmask;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         assign slot_done[gi] = done && (grant_reg == 1'(gi));

         mem_req_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .strb       (port_strb[gi]),
            .addr       (port_addr[gi]),
            .wdata      (port_wdata[gi]),
            .wmask      (port_wmask[gi]),
            .op         (port_op[gi]),
            .done       (slot_done[gi]),
            .mem_rdata  (mem_rdata),
            .pending    (slot_pending[gi]),
            .op_cur     (slot_op[gi]),
            .req_now    (slot_req[gi]),
            .addr_next  (slot_addr_next[gi]),
            .wdata_next (slot_wdata_next[gi]),
            .wmask_next (slot_wmask_next[gi]),
            .op_next    (slot_op_next[gi]),
            .rdata      (slot_rdata[gi])
         );
      end
   endgenerate

   assign sel_busy = (slot_op[grant_reg] == OP_WR) ? mem_wbusy : mem_rbusy;
   assign done     = (state_reg == WAIT) && !sel_busy;

`ifndef MEM_ARB_D_PRIORITY_EN
   logic rr_ptr_reg, rr_ptr_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr_reg <= PORT_I;
      else      rr_ptr_reg <= rr_ptr_next;
   end
`endif

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      load_issue = 1'b0;
`ifndef MEM_ARB_D_PRIORITY_EN
      rr_ptr_next = rr_ptr_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (|slot_req) begin
               load_issue = 1'b1;
               state_next = ISSUE;
               if (&slot_req) begin
`ifdef MEM_ARB_D_PRIORITY_EN
                  grant_next = PORT_D;
`else
                  grant_next  = rr_ptr_reg;
                  rr_ptr_next = ~rr_ptr_reg;
`endif
               end else begin
                  grant_next = slot_req[PORT_D] ? PORT_D : PORT_I;
               end
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (done) begin
               // Chain straight into the other port's request, no idle bubble.
               if (slot_pending[~grant_reg]) begin
                  grant_next = ~grant_reg;
                  load_issue = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         grant_reg     <= PORT_I;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_wmask_reg <= '0;
         mem_rstrb_reg <= 1'b0;
         mem_wstrb_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         mem_rstrb_reg <= load_issue && (slot_op_next[grant_next] == OP_RD);
         mem_wstrb_reg <= load_issue && (slot_op_next[grant_next] == OP_WR);
         if (load_issue) begin
            mem_addr_reg  <= slot_addr_next[grant_next];
            mem_wdata_reg <= slot_wdata_next[grant_next];
            mem_wmask_reg <= slot_wmask_next[grant_next];
         end
      end
   end

   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_wmask = mem_wmask_reg;
   assign mem_rstrb = mem_rstrb_reg;
   assign mem_wstrb = mem_wstrb_reg;

   assign i_rdata = slot_rdata[PORT_I];
   assign d_rdata = slot_rdata[PORT_D];
   assign i_rbusy = slot_pending[PORT_I];
   assign d_rbusy = slot_pending[PORT_D] && (slot_op[PORT_D] == OP_RD);
   assign d_wbusy = slot_pending[PORT_D] && (slot_op[PORT_D] == OP_WR);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing cases plus randomized I/D traffic
// against a RAM device model; expected read data comes from a separate reference memory.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_rstrb, d_wstrb, d_rstrb;
   logic [3:0]  d_wmask;
   logic [31:0] i_rdata, d_rdata;
   logic        i_rbusy, d_rbusy, d_wbusy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, mem_wstrb, mem_rbusy, mem_wbusy;

   typedef struct {
      logic        wr;
      logic [31:0] data;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_i[$];
   exp_t        exp_d[$];
   logic [31:0] ref_mem [256];
   logic [31:0] ram [256];
   int          ram_wait;
   bit          ram_rand;
   int          busy_cnt;
   logic        busy_wr;
   int          strobe_cnt = 0;
   bit          tie_d_next;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_rstrb(i_rstrb), .i_rdata(i_rdata), .i_rbusy(i_rbusy),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wstrb(d_wstrb),
      .d_rstrb(d_rstrb), .d_rdata(d_rdata), .d_rbusy(d_rbusy), .d_wbusy(d_wbusy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
   );

   function automatic logic [31:0] init_word(input int k);
      if (k == 64) return 32'hDEADBEEF;
      if (k == 8)  return 32'hAAAAAAAA;
      return (32'h9E3779B9 * (k + 1)) ^ 32'h5A5A0000;
   endfunction

   // RAM device: access happens at the strobe edge, busy lasts ram_wait cycles after issue.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_cnt  <= 0;
         busy_wr   <= 1'b0;
         mem_rdata <= '0;
         for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
      end else if (mem_rstrb || mem_wstrb) begin
         busy_cnt <= ram_rand ? int'($urandom_range(0, 2)) : ram_wait;
         busy_wr  <= mem_wstrb;
         if (mem_wstrb) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= ram[mem_addr[9:2]];
         end
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign mem_rbusy = (busy_cnt != 0) && !busy_wr;
   assign mem_wbusy = (busy_cnt != 0) && busy_wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ref_reset();
      for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
      tie_d_next = 1'b0;
   endtask

   task automatic ref_write(input int k, input logic [31:0] data, input logic [3:0] mask);
      for (int b = 0; b < 4; b++)
         if (mask[b]) ref_mem[k][8*b +: 8] = data[8*b +: 8];
   endtask

   // Ties alternate winners starting with I, unless D has fixed priority.
   function automatic bit tie_winner_d();
      bit w;
`ifdef MEM_ARB_D_PRIORITY_EN
      w = 1'b1;
`else
      w = tie_d_next;
      tie_d_next = !tie_d_next;
`endif
      return w;
   endfunction

   // Monitor: pops the scoreboard whenever a port's busy drops.
   initial begin
      bit          i_prev, dr_prev, dw_prev, s_prev;
      logic [31:0] last_d_rd;
      exp_t        e;
      logic [31:0] ei;
      forever begin
         @(negedge clk);
         if (!rst) begin
            i_prev = 0; dr_prev = 0; dw_prev = 0; s_prev = 0;
            last_d_rd = '0;
         end else begin
            if (mem_rstrb || mem_wstrb) begin
               strobe_cnt++;
               check1("strobe_exclusive", mem_rstrb & mem_wstrb, 1'b0);
               check1("issue_one_cycle", s_prev, 1'b0);
            end
            s_prev = mem_rstrb | mem_wstrb;
            if (i_prev && !i_rbusy) begin
               check1("i_done_expected", exp_i.size() != 0, 1'b1);
               if (exp_i.size() != 0) begin
                  ei = exp_i.pop_front();
                  check("i_rdata", i_rdata, ei);
               end
            end
            if (dr_prev && !d_rbusy) begin
               check1("d_rd_done_expected", exp_d.size() != 0, 1'b1);
               if (exp_d.size() != 0) begin
                  e = exp_d.pop_front();
                  check1("d_rd_op", e.wr, 1'b0);
                  check("d_rdata", d_rdata, e.data);
                  last_d_rd = e.data;
               end
            end
            if (dw_prev && !d_wbusy) begin
               check1("d_wr_done_expected", exp_d.size() != 0, 1'b1);
               if (exp_d.size() != 0) begin
                  e = exp_d.pop_front();
                  check1("d_wr_op", e.wr, 1'b1);
                  check("d_rdata_hold_on_write", d_rdata, last_d_rd);
               end
            end
            i_prev = i_rbusy; dr_prev = d_rbusy; dw_prev = d_wbusy;
         end
      end
   end

   task automatic wait_quiet();
      int n = 0;
      while ((i_rbusy || d_rbusy || d_wbusy || exp_i.size() != 0 || exp_d.size() != 0) && n < 300) begin
         cyc();
         n++;
      end
      check1("quiet_timeout", i_rbusy | d_rbusy | d_wbusy, 1'b0);
   endtask

   task automatic arb_round(input bit d_first);
      logic [31:0] a1, a2;
      exp_t e;
      a1 = d_first ? 32'h40 : 32'h0;
      a2 = d_first ? 32'h0 : 32'h40;
      cyc();
      i_addr = 32'h0;  i_rstrb = 1'b1;
      d_addr = 32'h40; d_rstrb = 1'b1;
      exp_i.push_back(ref_mem[0]);
      e.wr = 1'b0; e.data = ref_mem[16];
      exp_d.push_back(e);
      cyc();
      i_rstrb = 1'b0; d_rstrb = 1'b0;
      @(negedge clk);
      check1("arb_first_rstrb", mem_rstrb, 1'b1);
      check("arb_first_addr", mem_addr, a1);
      cyc();
      @(negedge clk);
      check1("arb_gap_rstrb", mem_rstrb, 1'b0);
      cyc();
      @(negedge clk);
      check1("arb_second_rstrb", mem_rstrb, 1'b1);
      check("arb_second_addr", mem_addr, a2);
      wait_quiet();
   endtask

   task automatic wait_free_i();
      int n = 0;
      while (i_rbusy && n < 300) begin cyc(); n++; end
      check1("i_free_timeout", i_rbusy, 1'b0);
   endtask

   task automatic wait_free_d();
      int n = 0;
      while ((d_rbusy || d_wbusy) && n < 300) begin cyc(); n++; end
      check1("d_free_timeout", d_rbusy | d_wbusy, 1'b0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   sc, k;
      rst = 1'b0;
      i_addr = '0; i_rstrb = 1'b0;
      d_addr = '0; d_wdata = '0; d_wmask = '0; d_wstrb = 1'b0; d_rstrb = 1'b0;
      ram_wait = 0; ram_rand = 1'b0;
      ref_reset();
      repeat (3) cyc();
      @(negedge clk);
      check1("rst_i_rbusy", i_rbusy, 1'b0);
      check1("rst_d_rbusy", d_rbusy, 1'b0);
      check1("rst_d_wbusy", d_wbusy, 1'b0);
      check1("rst_mem_rstrb", mem_rstrb, 1'b0);
      check1("rst_mem_wstrb", mem_wstrb, 1'b0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      cyc();
      rst = 1'b1;

      // Simultaneous I and D reads, twice.
      arb_round(tie_winner_d());
      arb_round(tie_winner_d());

      // Uncontended fetch latency.
      cyc();
      i_addr = 32'h100; i_rstrb = 1'b1;
      exp_i.push_back(ref_mem[64]);
      cyc();
      i_rstrb = 1'b0;
      @(negedge clk);
      check1("fetch_c1_rstrb", mem_rstrb, 1'b1);
      check("fetch_c1_addr", mem_addr, 32'h100);
      check1("fetch_c1_busy", i_rbusy, 1'b1);
      cyc();
      @(negedge clk);
      check1("fetch_c2_busy", i_rbusy, 1'b1);
      check1("fetch_c2_rstrb", mem_rstrb, 1'b0);
      cyc();
      @(negedge clk);
      check1("fetch_c3_busy", i_rbusy, 1'b0);
      check("fetch_c3_rdata", i_rdata, 32'hDEADBEEF);
      wait_quiet();

      // Partial write then read back.
      cyc();
      d_addr = 32'h20; d_wdata = 32'h12345678; d_wmask = 4'b0011; d_wstrb = 1'b1;
      ref_write(8, 32'h12345678, 4'b0011);
      e.wr = 1'b1; e.data = '0;
      exp_d.push_back(e);
      cyc();
      d_wstrb = 1'b0;
      @(negedge clk);
      check1("wr_c1_wbusy", d_wbusy, 1'b1);
      check1("wr_c1_rbusy", d_rbusy, 1'b0);
      check1("wr_c1_wstrb", mem_wstrb, 1'b1);
      check("wr_c1_wmask", 32'(mem_wmask), 32'h3);
      check("wr_c1_wdata", mem_wdata, 32'h12345678);
      wait_quiet();
      cyc();
      d_addr = 32'h20; d_rstrb = 1'b1;
      e.wr = 1'b0; e.data = ref_mem[8];
      exp_d.push_back(e);
      cyc();
      d_rstrb = 1'b0;
      wait_quiet();
      check("rd_after_wr", d_rdata, 32'hAAAA5678);

      // Slow memory; a second strobe while busy must be dropped.
      ram_wait = 3;
      sc = strobe_cnt;
      cyc();
      i_addr = 32'h104; i_rstrb = 1'b1;
      exp_i.push_back(ref_mem[65]);
      for (int c = 1; c <= 6; c++) begin
         cyc();
         i_rstrb = (c == 2);
         i_addr  = (c == 2) ? 32'h108 : 32'h104;
         @(negedge clk);
         check1("slow_i_rbusy", i_rbusy, c <= 5);
      end
      wait_quiet();
      check("slow_strobe_count", 32'(strobe_cnt - sc), 32'd1);

      // Reset in WAIT with both slots pending.
      ram_wait = 5;
      cyc();
      i_addr = 32'h0; i_rstrb = 1'b1;
      d_addr = 32'h200; d_rstrb = 1'b1;
      cyc();
      i_rstrb = 1'b0; d_rstrb = 1'b0;
      cyc();
      @(negedge clk);
      check1("pre_rst_i_busy", i_rbusy, 1'b1);
      check1("pre_rst_d_busy", d_rbusy, 1'b1);
      cyc();
      #2;
      rst = 1'b0;
      #1;
      check1("arst_i_rbusy", i_rbusy, 1'b0);
      check1("arst_d_rbusy", d_rbusy, 1'b0);
      check1("arst_d_wbusy", d_wbusy, 1'b0);
      check1("arst_mem_rstrb", mem_rstrb, 1'b0);
      check1("arst_mem_wstrb", mem_wstrb, 1'b0);
      exp_i.delete();
      exp_d.delete();
      ref_reset();
      ram_wait = 0;
      cyc();
      cyc();
      rst = 1'b1;
      sc = strobe_cnt;
      repeat (10) cyc();
      check("post_rst_no_strobe", 32'(strobe_cnt - sc), 32'd0);
      check1("post_rst_i_rbusy", i_rbusy, 1'b0);

      // Randomized concurrent traffic: I reads low region, D reads/writes high region.
      ram_rand = 1'b1;
      fork
         begin
            int ki;
            repeat (150) begin
               repeat ($urandom_range(0, 3)) cyc();
               wait_free_i();
               ki = int'($urandom_range(0, 127));
               i_addr = 32'(ki) << 2;
               i_rstrb = 1'b1;
               exp_i.push_back(ref_mem[ki]);
               cyc();
               i_rstrb = 1'b0;
            end
         end
         begin
            int   kd;
            exp_t ed;
            repeat (150) begin
               repeat ($urandom_range(0, 3)) cyc();
               wait_free_d();
               kd = 128 + int'($urandom_range(0, 127));
               d_addr = 32'(kd) << 2;
               if ($urandom_range(0, 1) == 1) begin
                  d_wdata = $urandom;
                  d_wmask = 4'($urandom_range(0, 15));
                  d_wstrb = 1'b1;
                  d_rstrb = ($urandom_range(0, 3) == 0);
                  ref_write(kd, d_wdata, d_wmask);
                  ed.wr = 1'b1; ed.data = '0;
               end else begin
                  d_rstrb = 1'b1;
                  ed.wr = 1'b0; ed.data = ref_mem[kd];
               end
               exp_d.push_back(ed);
               cyc();
               d_wstrb = 1'b0;
               d_rstrb = 1'b0;
            end
         end
      join
      wait_quiet();
      check("queues_drained", 32'(exp_i.size() + exp_d.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
